tick_mem_fill_scheduler: RTL and testbench

- Sequences refill of the timing-core tick memory.
- Detects the timing core's update_mem toggle, which signals that one bank has been consumed.
- Streams exactly one buffer of dt-tick words from an upstream valid/ready source into the inactive bank, using frame-interleaved addressing.
- Drives waddr/wdata/we/bank/mem_updated into timingCore, replacing ad-hoc fill logic in the laser synchronizer.

---
 rtl/tick_mem_fill_scheduler.sv | 175 +++++++++++++++++
 tb/tb_tick_mem_fill_scheduler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/tick_mem_fill_scheduler.sv
// tick_mem_fill_scheduler
//   Refills the inactive bank of the timing-core tick memory. Each level
//   change on update_mem_i asks for one full buffer of TOTAL_POINTS_P words.
//   The words are pulled from a valid/ready source. The source delivers point
//   p for every frame before moving on to point p+1. Each word is written to
//   address f*POINTS_PER_LINE_P + p.
//
// Ports
//   clk_i, nrst_i          clock, synchronous active-low reset
//   update_mem_i           bank-consumed toggle from timingCore
//   src_dt_i/src_active_i  beat payload
//   src_valid_i/src_ready_o  beat handshake
//   waddr_o/wdata_o/we_o   registered tick-memory write port
//   bank_sel_o             bank currently being filled
//   mem_updated_o          high when timingCore may switch banks
//   busy_o                 fill in progress (ARM or FILL)
//   overrun_o/ovr_clr_i    sticky dropped-request flag and its clear
module tick_mem_fill_scheduler #(
  parameter int POINTS_PER_LINE_P  = 360,
  parameter int NUMBER_OF_FRAMES_P = 5,
  parameter int ADDR_W_P           = 11,
  parameter int DT_W_P             = 16
) (
  input  logic                clk_i,
  input  logic                nrst_i,
  input  logic                update_mem_i,
  input  logic [DT_W_P-1:0]   src_dt_i,
  input  logic                src_active_i,
  input  logic                src_valid_i,
  output logic                src_ready_o,
  output logic [ADDR_W_P-1:0] waddr_o,
  output logic [DT_W_P:0]     wdata_o,
  output logic                we_o,
  output logic                bank_sel_o,
  output logic                mem_updated_o,
  output logic                busy_o,
  output logic                overrun_o,
  input  logic                ovr_clr_i
);

  localparam int TOTAL_POINTS_P = POINTS_PER_LINE_P * NUMBER_OF_FRAMES_P;
  localparam int F_W = (NUMBER_OF_FRAMES_P > 1) ? $clog2(NUMBER_OF_FRAMES_P) : 1;
  localparam logic [F_W-1:0]      F_LAST    = F_W'(NUMBER_OF_FRAMES_P - 1);
  localparam logic [ADDR_W_P-1:0] PPL_A     = ADDR_W_P'(POINTS_PER_LINE_P);
  // The final address of a buffer is reached only by its very last beat.
  localparam logic [ADDR_W_P-1:0] ADDR_LAST = ADDR_W_P'(TOTAL_POINTS_P - 1);

  typedef enum logic [1:0] {IDLE, ARM, FILL, DONE} state_t;

  state_t                state_q, state_d;
  logic                  s0_q, s1_q;
  logic                  req_w;
  logic                  pending_q;
  logic                  ovr_set;
  logic                  start;
  logic                  accept;
  logic                  last_beat;
  logic [F_W-1:0]        f_q;
  logic [ADDR_W_P-1:0]   p_q;
  logic [ADDR_W_P-1:0]   addr_q;
  logic                  vld_p1;
  logic [ADDR_W_P-1:0]   waddr_p1;
  logic [DT_W_P:0]       wdata_p1;
  logic                  bank_q;
  logic                  overrun_q;

  // Two-flop toggle synchroniser. The flops reset to 1, so an idle-high
  // update_mem_i raises no request when reset is released.
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      s0_q <= 1'b1;
      s1_q <= 1'b1;
    end else begin
      s0_q <= update_mem_i;
      s1_q <= s0_q;
    end
  end

  assign req_w     = s0_q ^ s1_q;
  assign start     = (state_q == IDLE) && (req_w || pending_q);
  assign accept    = (state_q == FILL) && src_valid_i;
  assign last_beat = (addr_q == ADDR_LAST);
  assign ovr_set   = (state_q != IDLE) && req_w && pending_q;

  always_ff @(posedge clk_i) begin
    if (!nrst_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    src_ready_o   = 1'b0;
    busy_o        = 1'b0;
    mem_updated_o = 1'b1;
    case (state_q)
      IDLE: if (start) state_d = ARM;
      ARM: begin
        busy_o        = 1'b1;
        mem_updated_o = 1'b0;
        state_d       = FILL;
      end
      FILL: begin
        busy_o        = 1'b1;
        mem_updated_o = 1'b0;
        src_ready_o   = 1'b1;
        if (accept && last_beat) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A start in IDLE consumes one request. If a new request arrives in the
  // same cycle as a start from pending, that new request stays queued.
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      bank_q    <= 1'b1;
    end else begin
      if (state_q == IDLE) begin
        if (start) pending_q <= pending_q & req_w;
      end else if (req_w && !pending_q) begin
        pending_q <= 1'b1;
      end
      if (start) bank_q <= ~bank_q;
      overrun_q <= ovr_set | (overrun_q & ~ovr_clr_i);
    end
  end

  // Incremental frame-interleaved addressing. Stepping to the next frame
  // adds one line. Wrapping back to frame 0 moves to the next point.
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      f_q    <= '0;
      p_q    <= '0;
      addr_q <= '0;
    end else if (state_q == ARM) begin
      f_q    <= '0;
      p_q    <= '0;
      addr_q <= '0;
    end else if (accept) begin
      if (f_q != F_LAST) begin
        f_q    <= f_q + F_W'(1);
        addr_q <= addr_q + PPL_A;
      end else begin
        f_q    <= '0;
        p_q    <= p_q + ADDR_W_P'(1);
        addr_q <= p_q + ADDR_W_P'(1);
      end
    end
  end

  // ---- stage p1: registered write port ----
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      vld_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        waddr_p1 <= addr_q;
        wdata_p1 <= {src_active_i, src_dt_i};
      end
    end
  end

  assign we_o       = vld_p1;
  assign waddr_o    = waddr_p1;
  assign wdata_o    = wdata_p1;
  assign bank_sel_o = bank_q;
  assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_tick_mem_fill_scheduler.sv
// tb_tick_mem_fill_scheduler
//   Directed bench for tick_mem_fill_scheduler with P=4 and F=2.
//   A buffer is 8 words, written to addresses 0,4,1,5,2,6,3,7.
module tb_tick_mem_fill_scheduler;

  logic        clk = 1'b0;
  logic        nrst;
  logic        update_mem;
  logic [15:0] dt;
  logic        active;
  logic        valid;
  logic        ready;
  logic [3:0]  waddr;
  logic [16:0] wdata;
  logic        we;
  logic        bank;
  logic        mem_upd;
  logic        busy;
  logic        overrun;
  logic        ovr_clr;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_addr [8] = '{0, 4, 1, 5, 2, 6, 3, 7};

  always #5 clk = ~clk;

  tick_mem_fill_scheduler #(
    .POINTS_PER_LINE_P (4),
    .NUMBER_OF_FRAMES_P(2),
    .ADDR_W_P          (4),
    .DT_W_P            (16)
  ) dut (
    .clk_i        (clk),
    .nrst_i       (nrst),
    .update_mem_i (update_mem),
    .src_dt_i     (dt),
    .src_active_i (active),
    .src_valid_i  (valid),
    .src_ready_o  (ready),
    .waddr_o      (waddr),
    .wdata_o      (wdata),
    .we_o         (we),
    .bank_sel_o   (bank),
    .mem_updated_o(mem_upd),
    .busy_o       (busy),
    .overrun_o    (overrun),
    .ovr_clr_i    (ovr_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Toggle the request, then walk through IDLE -> ARM -> FILL.
  task automatic start_fill(input logic exp_bank);
    update_mem = ~update_mem;
    step();
    chk("pre_arm_busy", 32'(busy), 32'd0);
    step();
    chk("arm_busy", 32'(busy), 32'd1);
    chk("arm_memupd", 32'(mem_upd), 32'd0);
    chk("arm_bank", 32'(bank), 32'(exp_bank));
    chk("arm_ready", 32'(ready), 32'd0);
    valid = 1'b1;
    step();
    chk("fill_ready", 32'(ready), 32'd1);
    chk("fill_no_we", 32'(we), 32'd0);
  endtask

  // Leave DONE, then restart directly from the pending request.
  task automatic restart(input logic exp_bank);
    step();
    chk("done_idle_busy", 32'(busy), 32'd0);
    chk("done_idle_we", 32'(we), 32'd0);
    step();
    chk("rearm_busy", 32'(busy), 32'd1);
    chk("rearm_bank", 32'(bank), 32'(exp_bank));
    chk("rearm_memupd", 32'(mem_upd), 32'd0);
    valid = 1'b1;
    step();
    chk("refill_ready", 32'(ready), 32'd1);
  endtask

  // Eight beats with valid held high. tog marks the beats during which
  // update_mem is toggled, and act gives the active bit of each beat.
  task automatic run_fill(input int base, input logic [7:0] tog, input logic [7:0] act);
    for (int i = 0; i < 8; i++) begin
      dt     = 16'(base + i);
      active = act[i];
      valid  = 1'b1;
      if (tog[i]) update_mem = ~update_mem;
      step();
      chk("fill_we", 32'(we), 32'd1);
      chk("fill_waddr", 32'(waddr), exp_addr[i]);
      chk("fill_wdata", 32'(wdata), {15'd0, act[i], 16'(base + i)});
      chk("fill_memupd", 32'(mem_upd), (i == 7) ? 32'd1 : 32'd0);
      chk("fill_ready_beat", 32'(ready), (i == 7) ? 32'd0 : 32'd1);
    end
    valid = 1'b0;
  endtask

  initial begin
    int beat;
    nrst = 1'b0; update_mem = 1'b1; dt = '0; active = 1'b0; valid = 1'b0; ovr_clr = 1'b0;
    repeat (3) step();
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_bank", 32'(bank), 32'd1);
    chk("rst_memupd", 32'(mem_upd), 32'd1);
    nrst = 1'b1;
    step();

    // Basic fill, with valid held high.
    start_fill(1'b0);
    run_fill(10, 8'h00, 8'hFF);
    step();
    chk("t1_idle_we", 32'(we), 32'd0);
    chk("t1_idle_memupd", 32'(mem_upd), 32'd1);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_hold_waddr", 32'(waddr), 32'd7);
    chk("t1_hold_wdata", 32'(wdata), 32'h10011);

    // Valid asserted only on every other cycle.
    start_fill(1'b1);
    beat = 0;
    for (int c = 0; c < 16; c++) begin
      valid  = (c % 2 == 0);
      dt     = 16'(20 + beat);
      active = beat[0];
      step();
      if (c % 2 == 0) begin
        chk("t2_we", 32'(we), 32'd1);
        chk("t2_waddr", 32'(waddr), exp_addr[beat]);
        chk("t2_wdata", 32'(wdata), {15'd0, beat[0], 16'(20 + beat)});
        beat++;
      end else begin
        chk("t2_stall_we", 32'(we), 32'd0);
      end
      chk("t2_memupd", 32'(mem_upd), (beat < 8) ? 32'd0 : 32'd1);
    end
    valid = 1'b0;
    chk("t2_end_busy", 32'(busy), 32'd0);

    // A second request during FILL is queued and serviced right after DONE.
    start_fill(1'b0);
    run_fill(30, 8'b0000_0100, 8'hFF);
    chk("t3_overrun", 32'(overrun), 32'd0);
    restart(1'b1);
    run_fill(40, 8'h00, 8'hF0);
    step();
    step();
    chk("t3_no_third_fill", 32'(busy), 32'd0);
    chk("t3_overrun_end", 32'(overrun), 32'd0);

    // Three requests in one fill: one is queued, the others set overrun.
    start_fill(1'b0);
    run_fill(50, 8'b0010_1010, 8'h0F);
    chk("t4_overrun_set", 32'(overrun), 32'd1);
    restart(1'b1);
    run_fill(60, 8'h00, 8'hFF);
    repeat (3) step();
    chk("t4_single_extra", 32'(busy), 32'd0);
    chk("t4_overrun_sticky", 32'(overrun), 32'd1);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("t4_overrun_clr", 32'(overrun), 32'd0);

    // Reset asserted after the third beat aborts the fill.
    start_fill(1'b0);
    for (int i = 0; i < 3; i++) begin
      dt = 16'(70 + i); active = 1'b1; valid = 1'b1;
      step();
      chk("t5_we", 32'(we), 32'd1);
      chk("t5_waddr", 32'(waddr), exp_addr[i]);
    end
    nrst = 1'b0;
    update_mem = 1'b1;
    step();
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_we", 32'(we), 32'd0);
    chk("t5_rst_bank", 32'(bank), 32'd1);
    chk("t5_rst_memupd", 32'(mem_upd), 32'd1);
    chk("t5_rst_ready", 32'(ready), 32'd0);
    nrst = 1'b1;

    // No request for 100 cycles, with the source still offering data.
    repeat (100) begin
      step();
      chk("t6_quiet_we", 32'(we), 32'd0);
      chk("t6_quiet_ready", 32'(ready), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
